// File: rtl/data_mem_bridge.sv
// Bridges the MIPS M-stage single-cycle data access onto a split addr/data handshake bus,
// stalling the pipeline while the access is outstanding and flagging misalignment or timeout.
module data_mem_bridge #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memenM,
   input  logic              memwriteM,
   input  logic [ADDR_W-1:0] aluoutM,
   input  logic [DATA_W-1:0] writedataM,
   output logic [DATA_W-1:0] readdataM,
   output logic              stallM,
   output logic              addr_errM,
   output logic              bus_errM,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
   // TIMEOUT bounds the stall cycles of one access, the request cycle in IDLE included
   localparam int unsigned TMO_LAST = (TIMEOUT > 2) ? (TIMEOUT - 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_tmo;
   logic              w_aligned;
   logic              w_cap;
   logic [ADDR_W-1:0] w_word_addr;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] w_rdata_nxt;
   logic              r_bus_err;
   logic              w_bus_err_nxt;

   assign w_cnt_inc   = r_cnt + CNT_W'(1);
   assign w_tmo       = (w_cnt_inc >= CNT_W'(TMO_LAST));
   assign w_aligned   = (aluoutM[1:0] == 2'b00);
   assign w_word_addr = {aluoutM[ADDR_W-1:2], 2'b00};

   // State register plus the request/response capture registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_rdata   <= '0;
         r_bus_err <= 1'b0;
         r_wr      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_rdata   <= w_rdata_nxt;
         r_bus_err <= w_bus_err_nxt;
         if (w_cap) begin
            r_wr    <= memwriteM;
            r_addr  <= w_word_addr;
            r_wdata <= writedataM;
         end
      end
   end

   // Next state and outputs; reset forces every output idle immediately
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_rdata_nxt   = r_rdata;
      w_bus_err_nxt = r_bus_err;
      w_cap         = 1'b0;
      readdataM     = '0;
      stallM        = 1'b0;
      addr_errM     = 1'b0;
      bus_errM      = 1'b0;
      bus_req       = 1'b0;
      bus_wr        = 1'b0;
      bus_addr      = '0;
      bus_wdata     = '0;

      if (rst) begin
         case (r_state)
            S_IDLE: begin
               if (memenM) begin
                  if (!w_aligned) begin
                     addr_errM = 1'b1;
                  end else begin
                     bus_req       = 1'b1;
                     bus_wr        = memwriteM;
                     bus_addr      = w_word_addr;
                     bus_wdata     = writedataM;
                     stallM        = 1'b1;
                     w_cap         = 1'b1;
                     w_cnt_nxt     = '0;
                     w_bus_err_nxt = 1'b0;
                     if (bus_addr_ok && bus_data_ok) begin
                        w_state_nxt = S_DONE;
                        w_rdata_nxt = memwriteM ? '0 : bus_rdata;
                     end else if (bus_addr_ok) begin
                        w_state_nxt = S_DATA;
                     end else begin
                        w_state_nxt = S_ADDR;
                     end
                  end
               end
            end
            S_ADDR: begin
               bus_req   = 1'b1;
               bus_wr    = r_wr;
               bus_addr  = r_addr;
               bus_wdata = r_wdata;
               stallM    = 1'b1;
               w_cnt_nxt = w_cnt_inc;
               if (bus_addr_ok && bus_data_ok) begin
                  w_state_nxt = S_DONE;
                  w_rdata_nxt = r_wr ? '0 : bus_rdata;
               end else if (w_tmo) begin
                  w_state_nxt   = S_DONE;
                  w_rdata_nxt   = '0;
                  w_bus_err_nxt = 1'b1;
               end else if (bus_addr_ok) begin
                  w_state_nxt = S_DATA;
               end
            end
            S_DATA: begin
               stallM    = 1'b1;
               w_cnt_nxt = w_cnt_inc;
               // a completion in the timeout cycle still counts as a normal completion
               if (bus_data_ok) begin
                  w_state_nxt = S_DONE;
                  w_rdata_nxt = r_wr ? '0 : bus_rdata;
               end else if (w_tmo) begin
                  w_state_nxt   = S_DONE;
                  w_rdata_nxt   = '0;
                  w_bus_err_nxt = 1'b1;
               end
            end
            S_DONE: begin
               readdataM   = r_rdata;
               bus_errM    = r_bus_err;
               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

endmodule
